stream_demux: RTL and testbench

- Registered 1-to-N stream demultiplexer: the steering counterpart to the team's mux family.
- Routes each beat on one valid/ready input stream to one of N output lanes, selected per beat by a lane index.
- Each output lane has a one-entry holding register, so a stalled lane blocks only beats addressed to it.
- Sits between a single producer (e.g. a decode/issue stage) and N independent consumers.
- Beats addressed to a nonexistent lane are dropped, flagged and counted.

---
 rtl/stream_demux_if.sv | 29 ++
 rtl/stream_demux.sv | 89 ++++++++
 tb/tb_stream_demux.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// Handshake bundle for stream_demux: one valid/ready input stream, N output lanes,
// plus the drop error pulse and saturating drop counter.
interface stream_demux_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 6,
  parameter int CW    = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [SELW-1:0]      in_sel;
  logic [N-1:0]         out_valid;
  logic [N-1:0]         out_ready;
  logic [N*WIDTH-1:0]   out_data;
  logic                 err;
  logic [CW-1:0]        drop_cnt;

  // Producer/consumer side that drives the demux
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, err, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, err, drop_cnt
  );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with a one-entry holding register per lane;
// beats addressed past the last lane are accepted, dropped, flagged and counted.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 6,
  parameter int CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  stream_demux_if.slave bus
);

  logic [N-1:0]     laneValid_q;
  logic [N-1:0]     laneValid_d;
  logic [WIDTH-1:0] laneData_q [N];
  logic [WIDTH-1:0] laneData_d [N];
  logic [N-1:0]     selHot;
  logic [N-1:0]     writeEn;
  logic [N-1:0]     drainEn;
  logic             selInRange;
  logic             inReady;
  logic             accept;
  logic             err_q;
  logic             err_d;
  logic [CW-1:0]    dropCnt_q;
  logic [CW-1:0]    dropCnt_d;

  // One-hot decode of the selector; an out-of-range selector decodes to all zeros,
  // which makes it always ready and writes no lane.
  always_comb begin
    selHot = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.in_sel == SELW'(i)) begin
        selHot[i] = 1'b1;
      end
    end
  end

  assign selInRange = |selHot;
  assign inReady    = ~|(selHot & laneValid_q & ~bus.out_ready);
  assign accept     = bus.in_valid & inReady;
  assign writeEn    = selHot & {N{accept}};
  assign drainEn    = laneValid_q & bus.out_ready;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      laneValid_d[i] = writeEn[i] | (laneValid_q[i] & ~drainEn[i]);
      laneData_d[i]  = writeEn[i] ? bus.in_data : laneData_q[i];
    end
  end

  // Drop bookkeeping: err mirrors each dropped beat one cycle later, counter saturates
  always_comb begin
    err_d     = accept & ~selInRange;
    dropCnt_d = dropCnt_q;
    if (err_d && (dropCnt_q != {CW{1'b1}})) begin
      dropCnt_d = dropCnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      laneValid_q <= '0;
      err_q       <= 1'b0;
      dropCnt_q   <= '0;
      for (int i = 0; i < N; i++) begin
        laneData_q[i] <= '0;
      end
    end else begin
      laneValid_q <= laneValid_d;
      err_q       <= err_d;
      dropCnt_q   <= dropCnt_d;
      for (int i = 0; i < N; i++) begin
        laneData_q[i] <= laneData_d[i];
      end
    end
  end

  assign bus.in_ready  = inReady;
  assign bus.out_valid = laneValid_q;
  assign bus.err       = err_q;
  assign bus.drop_cnt  = dropCnt_q;

  for (genvar g = 0; g < N; g++) begin : gLaneOut
    assign bus.out_data[g*WIDTH +: WIDTH] = laneData_q[g];
  end

endmodule

// File: tb/tb_stream_demux.sv
// Directed, table-driven bench for stream_demux: a default 4-lane instance plus a
// CW=2 instance for counter saturation.
module tb_stream_demux;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stream_demux_if #(.WIDTH(8), .N(4), .SELW(6), .CW(8)) busA ();
  stream_demux_if #(.WIDTH(8), .N(4), .SELW(6), .CW(2)) busB ();

  stream_demux #(.WIDTH(8), .N(4), .SELW(6), .CW(8)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA.slave)
  );

  stream_demux #(.WIDTH(8), .N(4), .SELW(6), .CW(2)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB.slave)
  );

  typedef struct packed {
    logic        v;
    logic [5:0]  sel;
    logic [7:0]  data;
    logic [3:0]  rdy;
    logic        expReady;
    logic [3:0]  expValid;
    logic [31:0] expData;
    logic        expErr;
    logic [7:0]  expDrop;
  } vec_t;

  vec_t vecs [21];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one cycle on instance A: check in_ready before the edge, state after it
  task automatic applyStimulus(input int idx, input vec_t vc);
    @(negedge clk);
    busA.in_valid  = vc.v;
    busA.in_sel    = vc.sel;
    busA.in_data   = vc.data;
    busA.out_ready = vc.rdy;
    #1;
    checkOutput($sformatf("vec%0d in_ready", idx), 32'(busA.in_ready), 32'(vc.expReady));
    @(posedge clk);
    #1;
    checkOutput($sformatf("vec%0d out_valid", idx), 32'(busA.out_valid), 32'(vc.expValid));
    checkOutput($sformatf("vec%0d out_data", idx), busA.out_data, vc.expData);
    checkOutput($sformatf("vec%0d err", idx), 32'(busA.err), 32'(vc.expErr));
    checkOutput($sformatf("vec%0d drop_cnt", idx), 32'(busA.drop_cnt), 32'(vc.expDrop));
  endtask

  initial begin
    busA.in_valid = 1'b0; busA.in_sel = '0; busA.in_data = '0; busA.out_ready = 4'hF;
    busB.in_valid = 1'b0; busB.in_sel = '0; busB.in_data = '0; busB.out_ready = 4'hF;

    // Lane 2 single beat, then drain
    vecs[0] = '{1'b1, 6'd2, 8'hA5, 4'hF, 1'b1, 4'b0100, 32'h00A5_0000, 1'b0, 8'd0};
    vecs[1] = '{1'b0, 6'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00A5_0000, 1'b0, 8'd0};
    // Lane 1 back-to-back stream 01..08
    for (int k = 1; k <= 8; k++) begin
      vecs[1+k] = '{1'b1, 6'd1, 8'(k), 4'hF, 1'b1, 4'b0010,
                    32'h00A5_0000 | (32'(k) << 8), 1'b0, 8'd0};
    end
    vecs[10] = '{1'b0, 6'd0, 8'h00, 4'hF, 1'b1, 4'b0000, 32'h00A5_0800, 1'b0, 8'd0};
    // Lane 3 stalled, lane 0 unaffected, then same-edge drain/fill on lane 3
    vecs[11] = '{1'b1, 6'd3, 8'h11, 4'b0111, 1'b1, 4'b1000, 32'h11A5_0800, 1'b0, 8'd0};
    vecs[12] = '{1'b1, 6'd3, 8'h22, 4'b0111, 1'b0, 4'b1000, 32'h11A5_0800, 1'b0, 8'd0};
    vecs[13] = '{1'b1, 6'd0, 8'h33, 4'b0111, 1'b1, 4'b1001, 32'h11A5_0833, 1'b0, 8'd0};
    vecs[14] = '{1'b1, 6'd3, 8'h22, 4'b1110, 1'b1, 4'b1001, 32'h22A5_0833, 1'b0, 8'd0};
    vecs[15] = '{1'b0, 6'd0, 8'h00, 4'b0000, 1'b0, 4'b1001, 32'h22A5_0833, 1'b0, 8'd0};
    vecs[16] = '{1'b0, 6'd0, 8'h00, 4'hF,    1'b1, 4'b0000, 32'h22A5_0833, 1'b0, 8'd0};
    // Invalid selectors back-to-back, then idle with an invalid selector present
    vecs[17] = '{1'b1, 6'd5,  8'h77, 4'hF, 1'b1, 4'b0000, 32'h22A5_0833, 1'b1, 8'd1};
    vecs[18] = '{1'b1, 6'd63, 8'h88, 4'hF, 1'b1, 4'b0000, 32'h22A5_0833, 1'b1, 8'd2};
    vecs[19] = '{1'b0, 6'd0,  8'h00, 4'hF, 1'b1, 4'b0000, 32'h22A5_0833, 1'b0, 8'd2};
    vecs[20] = '{1'b0, 6'd5,  8'h99, 4'hF, 1'b1, 4'b0000, 32'h22A5_0833, 1'b0, 8'd2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(busA.out_valid), 32'h0);
    checkOutput("reset in_ready", 32'(busA.in_ready), 32'h1);
    checkOutput("reset err", 32'(busA.err), 32'h0);
    checkOutput("reset drop_cnt", 32'(busA.drop_cnt), 32'h0);
    checkOutput("reset out_data", busA.out_data, 32'h0);

    for (int i = 0; i < 21; i++) begin
      applyStimulus(i, vecs[i]);
    end
    @(negedge clk);
    busA.in_valid = 1'b0;

    // Saturating counter on the CW=2 instance
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      busB.in_valid = 1'b1;
      busB.in_sel   = 6'd7;
      busB.in_data  = 8'(k);
      @(posedge clk);
      #1;
      checkOutput($sformatf("sat%0d drop_cnt", k), 32'(busB.drop_cnt), (k < 3) ? 32'(k) : 32'd3);
      checkOutput($sformatf("sat%0d err", k), 32'(busB.err), 32'h1);
      checkOutput($sformatf("sat%0d out_valid", k), 32'(busB.out_valid), 32'h0);
    end
    @(negedge clk);
    busB.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("sat idle err", 32'(busB.err), 32'h0);
    checkOutput("sat idle drop_cnt", 32'(busB.drop_cnt), 32'd3);

    // Asynchronous reset while lane 3 is stalled
    @(negedge clk);
    busA.in_valid  = 1'b1;
    busA.in_sel    = 6'd3;
    busA.in_data   = 8'h11;
    busA.out_ready = 4'b0000;
    @(posedge clk);
    #1;
    checkOutput("stall out_valid", 32'(busA.out_valid), 32'h8);
    busA.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async out_valid", 32'(busA.out_valid), 32'h0);
    checkOutput("async out_data", busA.out_data, 32'h0);
    checkOutput("async drop_cnt", 32'(busA.drop_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post-reset out_valid", 32'(busA.out_valid), 32'h0);
    checkOutput("post-reset in_ready", 32'(busA.in_ready), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
